sr_cmd_sequencer: RTL

- Upstream driver for the gated SR latch: turns two raw, bouncy request inputs (set and clear) into clean, registered s/r/en command pulses.
- Guarantees the latch never sees s=r=1.
- Fixes the enable window width and inserts a guard cycle between commands.
- Queues at most one pending request per type, served in arrival order.

---
 rtl/sr_cmd_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sr_cmd_sequencer.sv
// Turns bouncy set/clear requests into clean, registered s/r/en pulses for a gated SR latch.
// Keeps s and r mutually exclusive, and separates consecutive commands with a guard cycle.
module sr_cmd_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {IDLE, SET_HOLD, CLR_HOLD, GUARD} state_e;

  localparam logic [7:0] DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_CYCLES);

  logic [1:0] setSync_q, clrSync_q;
  logic [7:0] setCnt_q, setCnt_d, clrCnt_q, clrCnt_d;
  logic       setDeb_q, setDeb_d, clrDeb_q, clrDeb_d;
  logic       setDebPrev_q, clrDebPrev_q;
  logic       pendSet_q, pendSet_d, pendClr_q, pendClr_d;
  logic       orderClr_q, orderClr_d;
  logic       conflict_q, conflict_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  state_e     state_q, state_d;
  logic       s_q, s_d, r_q, r_d, en_q, en_d;
  logic       setEv, clrEv, serveSet, serveClr;

  // Debounced value only follows after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    setCnt_d = '0;
    setDeb_d = setDeb_q;
    if (setSync_q[1] != setDeb_q) begin
      if (setCnt_q + 8'd1 == DB_LIMIT) setDeb_d = ~setDeb_q;
      else                             setCnt_d = setCnt_q + 8'd1;
    end
    clrCnt_d = '0;
    clrDeb_d = clrDeb_q;
    if (clrSync_q[1] != clrDeb_q) begin
      if (clrCnt_q + 8'd1 == DB_LIMIT) clrDeb_d = ~clrDeb_q;
      else                             clrCnt_d = clrCnt_q + 8'd1;
    end
  end

  assign setEv = setDeb_q & ~setDebPrev_q;
  assign clrEv = clrDeb_q & ~clrDebPrev_q;

  assign serveSet = (state_q == IDLE) & pendSet_q & (~pendClr_q | ~orderClr_q);
  assign serveClr = (state_q == IDLE) & pendClr_q & (~pendSet_q |  orderClr_q);

  // orderClr_q set means the pending clear is older than the pending set.
  always_comb begin
    pendSet_d  = pendSet_q & ~serveSet;
    pendClr_d  = pendClr_q & ~serveClr;
    orderClr_d = orderClr_q;
    conflict_d = 1'b0;
    if (setEv && clrEv) begin
      conflict_d = 1'b1;
    end else if (setEv) begin
      if (!pendSet_d) begin
        pendSet_d  = 1'b1;
        orderClr_d = pendClr_d;
      end
    end else if (clrEv) begin
      if (!pendClr_d) begin
        pendClr_d  = 1'b1;
        orderClr_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    unique case (state_q)
      IDLE: begin
        if (serveSet) begin
          state_d   = SET_HOLD;
          holdCnt_d = 8'd1;
        end else if (serveClr) begin
          state_d   = CLR_HOLD;
          holdCnt_d = 8'd1;
        end
      end
      SET_HOLD, CLR_HOLD: begin
        if (holdCnt_q == HOLD_LIMIT) begin
          state_d   = GUARD;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered drive lines up with the state.
  always_comb begin
    s_d  = (state_d == SET_HOLD);
    r_d  = (state_d == CLR_HOLD);
    en_d = s_d | r_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      setSync_q    <= '0;
      clrSync_q    <= '0;
      setCnt_q     <= '0;
      clrCnt_q     <= '0;
      setDeb_q     <= 1'b0;
      clrDeb_q     <= 1'b0;
      setDebPrev_q <= 1'b0;
      clrDebPrev_q <= 1'b0;
      pendSet_q    <= 1'b0;
      pendClr_q    <= 1'b0;
      orderClr_q   <= 1'b0;
      conflict_q   <= 1'b0;
      holdCnt_q    <= '0;
      state_q      <= IDLE;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      setSync_q    <= {setSync_q[0], set_req};
      clrSync_q    <= {clrSync_q[0], clr_req};
      setCnt_q     <= setCnt_d;
      clrCnt_q     <= clrCnt_d;
      setDeb_q     <= setDeb_d;
      clrDeb_q     <= clrDeb_d;
      setDebPrev_q <= setDeb_q;
      clrDebPrev_q <= clrDeb_q;
      pendSet_q    <= pendSet_d;
      pendClr_q    <= pendClr_d;
      orderClr_q   <= orderClr_d;
      conflict_q   <= conflict_d;
      holdCnt_q    <= holdCnt_d;
      state_q      <= state_d;
      s_q          <= s_d;
      r_q          <= r_d;
      en_q         <= en_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign en       = en_q;
  assign conflict = conflict_q;
  assign busy     = (state_q != IDLE) | pendSet_q | pendClr_q;

endmodule
